fsbx_bridge: RTL and testbench

- Parametrised next-generation AHB-style to FSB bridge: multiplexed address/data front-side bus with configurable data width (8/16/32), full-width address in one ALE frame, and bridge-generated burst addresses.
- Adds page-crossing address re-issue, a burst-length cap and a bus-timeout abort.
- Sits between the core/AHB fabric and external FSB peripherals.

---
 rtl/fsbx_bridge_if.sv | 26 ++
 rtl/fsbx_bridge.sv | 182 ++++++++++++++++++
 tb/tb_fsbx_bridge.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsbx_bridge_if.sv
// AHB-side request/response bundle for fsbx_bridge.
// The fabric drives through the master modport; the bridge answers through the slave modport.
interface fsbx_bridge_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
);
  logic                  hsel;
  logic                  htrans;
  logic                  hburst;
  logic                  hwrite;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output hsel, htrans, hburst, hwrite, haddr, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, htrans, hburst, hwrite, haddr, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/fsbx_bridge.sv
// AHB-style to multiplexed front-side-bus bridge with page-cross/burst-cap address re-issue.
// Optional sync-mode bus timeout abort is enabled by defining FSBX_TIMEOUT_EN.
module fsbx_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_W     = 7,
  parameter int MAX_BURST  = 256,
  parameter int TIMEOUT    = 1023
) (
  input  logic                             hclk,
  input  logic                             hreset,
  input  logic                             sync_mode,
  input  logic [WAIT_W-1:0]                async_waitcycle,
  fsbx_bridge_if.slave                     ahb,
  output logic                             fsb_clk,
  output logic                             fsb_rst_n,
  output logic                             ale_n,
  output logic                             cs_n,
  output logic                             wr_n,
  output logic                             typ,
  input  logic                             rdy_n,
  input  logic                             err_n,
  input  logic                             irq_n,
  output logic                             fsb_irq,
  output logic                             ad_oe,
  output logic [ADDR_WIDTH-DATA_WIDTH-1:0] ah,
  output logic [DATA_WIDTH-1:0]            ad_out,
  input  logic [DATA_WIDTH-1:0]            ad_in
);

  localparam int STEP   = DATA_WIDTH / 8;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
`ifdef FSBX_TIMEOUT_EN
  localparam int TO_W   = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
`endif

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) ||
      ADDR_WIDTH <= DATA_WIDTH || ADDR_WIDTH < 9 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("fsbx_bridge: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_TURN, S_DATA} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic                  write_q, write_d;
  logic                  typ_q, typ_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [BEAT_W-1:0]     beat_q, beat_d, beat_inc;
  logic                  done, timed_out, hready_c, hresp_c;
`ifdef FSBX_TIMEOUT_EN
  logic [TO_W-1:0]       to_q, to_d;
`endif

  assign fsb_clk     = hclk;
  assign fsb_rst_n   = ~hreset;
  assign fsb_irq     = ~irq_n;
  assign typ         = typ_q;
  assign ah          = addr_q[ADDR_WIDTH-1:DATA_WIDTH];
  assign ahb.hrdata  = hrdata_q;
  assign ahb.hready  = hready_c;
  assign ahb.hresp   = hresp_c;
  assign addr_inc    = addr_q + ADDR_WIDTH'(STEP);
  assign beat_inc    = beat_q + 1'b1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hrdata_d  = hrdata_q;
    write_d   = write_q;
    typ_d     = typ_q;
    beat_d    = beat_q;
    wait_d    = '0;
`ifdef FSBX_TIMEOUT_EN
    to_d      = '0;
`endif
    ale_n     = 1'b1;
    cs_n      = 1'b1;
    wr_n      = 1'b1;
    ad_oe     = 1'b0;
    ad_out    = '0;
    hready_c  = 1'b0;
    hresp_c   = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        hready_c = 1'b1;
        if (ahb.hsel && ahb.htrans) begin
          addr_d  = ahb.haddr;
          write_d = ahb.hwrite;
          typ_d   = ahb.hburst;
          wdata_d = ahb.hwdata;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        ale_n   = 1'b0;
        ad_oe   = 1'b1;
        ad_out  = addr_q[DATA_WIDTH-1:0];
        state_d = write_q ? S_DATA : S_TURN;
      end

      S_TURN: state_d = S_DATA;

      S_DATA: begin
        cs_n   = 1'b0;
        wr_n   = ~write_q;
        ad_oe  = write_q;
        ad_out = wdata_q;
        done   = sync_mode ? ~rdy_n : (wait_q == async_waitcycle);
`ifdef FSBX_TIMEOUT_EN
        // A late rdy_n on the limit cycle still wins over the abort.
        if (sync_mode && rdy_n && (to_q == TO_W'(TIMEOUT))) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end
        if (sync_mode && !done) to_d = to_q + 1'b1;
`endif
        if (!done) begin
          wait_d = wait_q + 1'b1;
        end else begin
          hready_c = 1'b1;
          hresp_c  = ~err_n | timed_out;
          addr_d   = addr_inc;
          if (!write_q && !timed_out) hrdata_d = ad_in;
          if (ahb.hsel && ahb.htrans && ahb.hburst && !hresp_c) begin
            wdata_d = ahb.hwdata;
            if (addr_inc[7:0] == 8'h00 || beat_inc == BEAT_W'(MAX_BURST)) begin
              state_d = S_ADDR;
              beat_d  = '0;
            end else begin
              beat_d  = beat_inc;
            end
          end else begin
            state_d = S_IDLE;
            typ_d   = 1'b0;
            beat_d  = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (hreset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      hrdata_q <= '0;
      write_q  <= 1'b0;
      typ_q    <= 1'b0;
      wait_q   <= '0;
      beat_q   <= '0;
`ifdef FSBX_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hrdata_q <= hrdata_d;
      write_q  <= write_d;
      typ_q    <= typ_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
`ifdef FSBX_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_fsbx_bridge.sv
// Randomised burst bench for fsbx_bridge: a transaction-level schedule predicts every
// FSB pin and AHB response cycle by cycle; a second 16-bit instance gets a directed read.
module tb_fsbx_bridge;
  localparam int MAXB = 4;
  localparam int TO   = 15;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       sync_mode;
  logic [6:0] async_waitcycle;
  logic       rdy_n, err_n, irq_n;

  always #5 hclk = ~hclk;

  fsbx_bridge_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(32)) b8  ();
  fsbx_bridge_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) b16 ();

  logic        fsb_clk8, fsb_rst_n8, ale_n8, cs_n8, wr_n8, typ8, fsb_irq8, ad_oe8;
  logic [23:0] ah8;
  logic [7:0]  ad_out8, ad_in8;
  logic        fsb_clk16, fsb_rst_n16, ale_n16, cs_n16, wr_n16, typ16, fsb_irq16, ad_oe16;
  logic [15:0] ah16, ad_out16, ad_in16;

  fsbx_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .WAIT_W(7), .MAX_BURST(MAXB), .TIMEOUT(TO)) dut8 (
    .hclk(hclk), .hreset(hreset), .sync_mode(sync_mode), .async_waitcycle(async_waitcycle),
    .ahb(b8), .fsb_clk(fsb_clk8), .fsb_rst_n(fsb_rst_n8), .ale_n(ale_n8), .cs_n(cs_n8),
    .wr_n(wr_n8), .typ(typ8), .rdy_n(rdy_n), .err_n(err_n), .irq_n(irq_n), .fsb_irq(fsb_irq8),
    .ad_oe(ad_oe8), .ah(ah8), .ad_out(ad_out8), .ad_in(ad_in8)
  );

  fsbx_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut16 (
    .hclk(hclk), .hreset(hreset), .sync_mode(sync_mode), .async_waitcycle(async_waitcycle),
    .ahb(b16), .fsb_clk(fsb_clk16), .fsb_rst_n(fsb_rst_n16), .ale_n(ale_n16), .cs_n(cs_n16),
    .wr_n(wr_n16), .typ(typ16), .rdy_n(rdy_n), .err_n(err_n), .irq_n(irq_n), .fsb_irq(fsb_irq16),
    .ad_oe(ad_oe16), .ah(ah16), .ad_out(ad_out16), .ad_in(ad_in16)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_hrdata8 = 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_req8();
    b8.hsel = 1'b0; b8.htrans = 1'b0; b8.hburst = 1'b0; b8.hwrite = 1'b0;
    b8.haddr = '0;  b8.hwdata = '0;
  endtask

  task automatic junk_req8();
    b8.hsel = 1'($urandom); b8.htrans = 1'($urandom); b8.hburst = 1'($urandom);
    b8.hwrite = 1'($urandom); b8.haddr = $urandom; b8.hwdata = 8'($urandom);
  endtask

  task automatic rnd_fsb();
    rdy_n = 1'($urandom); err_n = 1'($urandom); irq_n = 1'($urandom); ad_in8 = 8'($urandom);
  endtask

  // One burst as seen from the pins. Called just after a negedge with the DUT idle.
  task automatic run_burst(input logic [31:0] start, input int nbeats, input bit wr, input bit sm,
                           input int wc, input int err_beat, input int dly_lo, input int dly_hi);
    logic [7:0]  data[$];
    logic [31:0] a;
    int          fb, dly, ndata;
    bit          err, tmo, last, last_beat, exp_typ;
    for (int i = 0; i < nbeats; i++) data.push_back(8'($urandom));
    exp_typ         = (nbeats > 1);
    sync_mode       = sm;
    async_waitcycle = 7'(wc);
    rnd_fsb();
    b8.hsel = 1'b1; b8.htrans = 1'b1; b8.hburst = exp_typ; b8.hwrite = wr;
    b8.haddr = start; b8.hwdata = data[0];
    #1;
    check("idle_hready", b8.hready, 1'b1);
    check("idle_ale_n", ale_n8, 1'b1);
    check("idle_cs_n", cs_n8, 1'b1);
    check("idle_ad_oe", ad_oe8, 1'b0);
    check("idle_typ", typ8, 1'b0);
    check("idle_hrdata", b8.hrdata, exp_hrdata8);
    check("fsb_irq", fsb_irq8, !irq_n);
    @(negedge hclk);
    a  = start;
    fb = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 0 || a[7:0] == 8'h00 || fb == MAXB) begin
        fb = 0;
        junk_req8(); rnd_fsb();
        #1;
        check("addr_ale_n", ale_n8, 1'b0);
        check("addr_cs_n", cs_n8, 1'b1);
        check("addr_ad_oe", ad_oe8, 1'b1);
        check("addr_ad_out", ad_out8, a[7:0]);
        check("addr_ah", ah8, a[31:8]);
        check("addr_hready", b8.hready, 1'b0);
        check("addr_typ", typ8, exp_typ);
        @(negedge hclk);
        if (!wr) begin
          junk_req8(); rnd_fsb();
          #1;
          check("turn_ale_n", ale_n8, 1'b1);
          check("turn_cs_n", cs_n8, 1'b1);
          check("turn_wr_n", wr_n8, 1'b1);
          check("turn_ad_oe", ad_oe8, 1'b0);
          check("turn_hready", b8.hready, 1'b0);
          @(negedge hclk);
        end
      end
      dly   = $urandom_range(dly_hi, dly_lo);
      tmo   = 1'b0;
      ndata = sm ? dly + 1 : wc + 1;
`ifdef FSBX_TIMEOUT_EN
      if (sm && dly > TO) begin
        tmo   = 1'b1;
        ndata = TO + 1;
      end
`endif
      err       = (b == err_beat);
      last_beat = (b == nbeats - 1) || err || tmo;
      for (int c = 0; c < ndata; c++) begin
        last = (c == ndata - 1);
        rnd_fsb();
        if (sm) rdy_n = !(c == dly);
        if (last) begin
          err_n = !err;
          if (b == nbeats - 1) begin
            junk_req8();
            b8.hburst = 1'b0;
          end else begin
            b8.hsel = 1'b1; b8.htrans = 1'b1; b8.hburst = 1'b1;
            b8.hwrite = 1'($urandom); b8.haddr = $urandom; b8.hwdata = data[b+1];
          end
        end else begin
          junk_req8();
        end
        #1;
        check("data_ale_n", ale_n8, 1'b1);
        check("data_cs_n", cs_n8, 1'b0);
        check("data_wr_n", wr_n8, !wr);
        check("data_ad_oe", ad_oe8, wr);
        if (wr) check("data_ad_out", ad_out8, data[b]);
        check("data_ah", ah8, a[31:8]);
        check("data_hready", b8.hready, last);
        check("data_hresp", b8.hresp, last && (err || tmo));
        check("data_hrdata", b8.hrdata, exp_hrdata8);
        check("data_typ", typ8, exp_typ);
        if (last && !wr && !tmo) exp_hrdata8 = ad_in8;
        @(negedge hclk);
      end
      a = a + 32'd1;
      fb++;
      if (last_beat) break;
    end
    idle_req8();
  endtask

  initial begin
    logic [31:0] r, start;
    int          nb, eb, dhi;
    hreset = 1'b1;
    sync_mode = 1'b0; async_waitcycle = '0; rdy_n = 1'b1; err_n = 1'b1; irq_n = 1'b1;
    ad_in8 = '0; ad_in16 = '0;
    idle_req8();
    b16.hsel = 1'b0; b16.htrans = 1'b0; b16.hburst = 1'b0; b16.hwrite = 1'b0;
    b16.haddr = '0; b16.hwdata = '0;
    repeat (3) @(negedge hclk);
    #1;
    check("rst_hready", b8.hready, 1'b1);
    check("rst_ale_n", ale_n8, 1'b1);
    check("rst_cs_n", cs_n8, 1'b1);
    check("rst_wr_n", wr_n8, 1'b1);
    check("rst_ad_oe", ad_oe8, 1'b0);
    check("rst_typ", typ8, 1'b0);
    check("rst_hrdata", b8.hrdata, 8'h00);
    check("rst_hresp", b8.hresp, 1'b0);
    check("rst_fsb_rst_n", fsb_rst_n8, 1'b0);
    check("fsb_clk_lo", fsb_clk8, hclk);
    hreset = 1'b0;
    @(posedge hclk); #1;
    check("fsb_clk_hi", fsb_clk8, hclk);
    check("fsb_rst_n", fsb_rst_n8, 1'b1);
    @(negedge hclk);

    // 16-bit async read, 3 extra wait cycles: ALE, TURN, four DATA cycles.
    sync_mode = 1'b0; async_waitcycle = 7'd3; ad_in16 = 16'hBEEF;
    b16.hsel = 1'b1; b16.htrans = 1'b1; b16.haddr = 32'h0000_0100;
    #1 check("w16_idle_hready", b16.hready, 1'b1);
    @(negedge hclk);
    b16.hsel = 1'b0; b16.htrans = 1'b0;
    #1;
    check("w16_ale_n", ale_n16, 1'b0);
    check("w16_ad_out", ad_out16, 16'h0100);
    check("w16_ah", ah16, 16'h0000);
    @(negedge hclk); #1;
    check("w16_turn_ad_oe", ad_oe16, 1'b0);
    check("w16_turn_cs_n", cs_n16, 1'b1);
    check("w16_turn_hready", b16.hready, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge hclk); #1;
      check("w16_data_cs_n", cs_n16, 1'b0);
      check("w16_data_hready", b16.hready, c == 3);
    end
    @(negedge hclk); #1;
    check("w16_hrdata", b16.hrdata, 16'hBEEF);
    check("w16_back_idle", cs_n16, 1'b1);
    @(negedge hclk);

    // Directed scenarios on the 8-bit instance.
    run_burst(32'h1234_5678, 1, 1'b1, 1'b1, 0, -1, 0, 0);
    run_burst(32'h0000_20FE, 4, 1'b0, 1'b1, 0, -1, 0, 2);
    run_burst(32'h1000_0010, 6, 1'b1, 1'b1, 0, -1, 0, 1);
    run_burst(32'h0000_4000, 4, 1'b1, 1'b1, 0, 1, 0, 2);
    run_burst(32'hFFFF_FFFE, 4, 1'b0, 1'b0, 2, -1, 0, 0);
`ifdef FSBX_TIMEOUT_EN
    run_burst(32'h0000_3000, 2, 1'b0, 1'b1, 0, -1, 30, 30);
    run_burst(32'h0000_3100, 1, 1'b0, 1'b1, 0, -1, TO, TO);
`endif

    for (int t = 0; t < 60; t++) begin
      r = $urandom;
      case ($urandom_range(2, 0))
        0:       start = r;
        1:       start = {r[31:8], 8'(8'hF8 + $urandom_range(7, 0))};
        default: start = {r[31:8], 8'(r[7:0] & 8'h3F)};
      endcase
      nb  = $urandom_range(8, 1);
      eb  = ($urandom_range(3, 0) == 0) ? $urandom_range(nb - 1, 0) : -1;
      dhi = 3;
`ifdef FSBX_TIMEOUT_EN
      if ($urandom_range(4, 0) == 0) dhi = 20;
`endif
      run_burst(start, nb, 1'($urandom), 1'($urandom), $urandom_range(3, 0), eb, 0, dhi);
    end

    // Reset in the middle of a write data phase.
    sync_mode = 1'b1; rdy_n = 1'b1; err_n = 1'b1;
    b8.hsel = 1'b1; b8.htrans = 1'b1; b8.hburst = 1'b1; b8.hwrite = 1'b1;
    b8.haddr = 32'h55AA_0010; b8.hwdata = 8'h3C;
    @(negedge hclk);
    idle_req8();
    #1 check("mid_ale_n", ale_n8, 1'b0);
    @(negedge hclk); #1;
    check("mid_cs_n", cs_n8, 1'b0);
    hreset = 1'b1;
    @(negedge hclk); #1;
    check("mid_rst_cs_n", cs_n8, 1'b1);
    check("mid_rst_wr_n", wr_n8, 1'b1);
    check("mid_rst_ad_oe", ad_oe8, 1'b0);
    check("mid_rst_hready", b8.hready, 1'b1);
    check("mid_rst_typ", typ8, 1'b0);
    check("mid_rst_hrdata", b8.hrdata, 8'h00);
    hreset = 1'b0;
    exp_hrdata8 = 8'h00;
    @(negedge hclk); #1;
    check("final_idle_hready", b8.hready, 1'b1);
    check("final_idle_ale_n", ale_n8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
